// File: rtl/alu_op_sequencer_pkg.sv
// ============================================================================
// Module   : alu_op_sequencer_pkg
// Brief    : Shared ISA opcode encodings, ALU mode encodings and sequencer
//            state encodings for the immediate-operand ALU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_op_sequencer_pkg;

   // Instruction opcodes (immediate-operand group plus move-immediate)
   localparam logic [3:0] OP_MI  = 4'b0010;
   localparam logic [3:0] OP_ORI = 4'b1001;
   localparam logic [3:0] OP_XRI = 4'b1011;
   localparam logic [3:0] OP_SMI = 4'b1100;
   localparam logic [3:0] OP_SBI = 4'b1101;
   localparam logic [3:0] OP_ANI = 4'b1110;
   localparam logic [3:0] OP_CMI = 4'b1111;

   // ALU mode encodings presented on the mode output
   localparam logic [2:0] MODE_ADD = 3'b000;
   localparam logic [2:0] MODE_SUB = 3'b001;
   localparam logic [2:0] MODE_AND = 3'b100;
   localparam logic [2:0] MODE_OR  = 3'b101;
   localparam logic [2:0] MODE_XOR = 3'b110;
   localparam logic [2:0] MODE_CMP = 3'b111;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_ALU  = 3'd2,
      ST_CAP  = 3'd3,
      ST_WB   = 3'd4,
      ST_DONE = 3'd5
   } state_e;

endpackage : alu_op_sequencer_pkg

`default_nettype wire

// File: rtl/alu_op_sequencer_decode.sv
// ============================================================================
// Module   : alu_op_decode
// Brief    : Combinational opcode decoder. Classifies an opcode as an ALU
//            operation (with its mode), a compare, a move-immediate or an
//            illegal encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_decode
   import alu_op_sequencer_pkg::*;
(
   input  logic [3:0] opcode,
   output logic [2:0] mode,
   output logic       is_alu,
   output logic       is_cmp,
   output logic       is_mov,
   output logic       illegal
);

   // Opcode classification; anything not listed is reported as illegal
   always_comb begin
      mode    = MODE_ADD;
      is_alu  = 1'b0;
      is_cmp  = 1'b0;
      is_mov  = 1'b0;
      illegal = 1'b0;
      case (opcode)
         OP_SMI: begin
            mode   = MODE_ADD;
            is_alu = 1'b1;
         end
         OP_SBI: begin
            mode   = MODE_SUB;
            is_alu = 1'b1;
         end
         OP_ANI: begin
            mode   = MODE_AND;
            is_alu = 1'b1;
         end
         OP_ORI: begin
            mode   = MODE_OR;
            is_alu = 1'b1;
         end
         OP_XRI: begin
            mode   = MODE_XOR;
            is_alu = 1'b1;
         end
         OP_CMI: begin
            mode   = MODE_CMP;
            is_alu = 1'b1;
            is_cmp = 1'b1;
         end
         OP_MI: begin
            is_mov = 1'b1;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule : alu_op_decode

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Control sequencer for immediate-operand ALU instructions. Reads
//            rs, runs the ALU against the immediate, captures result and
//            flags, and writes the result back to rd. Compares update flags
//            only; move-immediate writes imm directly; illegal opcodes
//            complete immediately with the illegal indication.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int SEL_W    = 2,
   parameter int ALU_WAIT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        opcode,
   input  logic [DATA_W-1:0] imm,
   input  logic [SEL_W-1:0]  rs,
   input  logic [SEL_W-1:0]  rd,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_carry,
   output logic [SEL_W-1:0]  register_select,
   output logic              mem_enable,
   output logic              read_write,
   output logic [DATA_W-1:0] data_bus_in,
   output logic              alu_enable,
   output logic [2:0]        mode,
   output logic [DATA_W-1:0] immediate_input,
   output logic              busy,
   output logic              done,
   output logic              illegal,
   output logic              zero_flag,
   output logic              carry_flag
);

   // The wait counter only ever holds values 0 .. ALU_WAIT-1
   localparam int               CNT_W    = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_WAIT - 1);

   // Decoder outputs for the opcode currently presented at the input
   logic [2:0] dec_mode;
   logic       dec_is_alu;
   logic       dec_is_cmp;
   logic       dec_is_mov;
   logic       dec_illegal;

   // Sequencer state and instruction latches
   state_e            state_q,   state_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic [2:0]        mode_q,    mode_d;
   logic              cmp_q,     cmp_d;
   logic              illegal_q, illegal_d;
   logic [DATA_W-1:0] imm_q,     imm_d;
   logic [SEL_W-1:0]  rs_q,      rs_d;
   logic [SEL_W-1:0]  rd_q,      rd_d;

   // Result and flag capture; result_q doubles as the write-back data
   logic [DATA_W-1:0] result_q,  result_d;
   logic              zero_q,    zero_d;
   logic              carry_q,   carry_d;

   alu_op_decode u_decode (
      .opcode  (opcode),
      .mode    (dec_mode),
      .is_alu  (dec_is_alu),
      .is_cmp  (dec_is_cmp),
      .is_mov  (dec_is_mov),
      .illegal (dec_illegal)
   );

   // State register and all capture registers; reset aborts any operation
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         mode_q    <= '0;
         cmp_q     <= 1'b0;
         illegal_q <= 1'b0;
         imm_q     <= '0;
         rs_q      <= '0;
         rd_q      <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mode_q    <= mode_d;
         cmp_q     <= cmp_d;
         illegal_q <= illegal_d;
         imm_q     <= imm_d;
         rs_q      <= rs_d;
         rd_q      <= rd_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         carry_q   <= carry_d;
      end
   end

   // Next-state logic and per-state control outputs
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      mode_d          = mode_q;
      cmp_d           = cmp_q;
      illegal_d       = illegal_q;
      imm_d           = imm_q;
      rs_d            = rs_q;
      rd_d            = rd_q;
      result_d        = result_q;
      zero_d          = zero_q;
      carry_d         = carry_q;

      register_select = '0;
      mem_enable      = 1'b0;
      read_write      = 1'b1;
      data_bus_in     = '0;
      alu_enable      = 1'b0;
      mode            = '0;
      immediate_input = '0;
      done            = 1'b0;
      illegal         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               imm_d     = imm;
               rs_d      = rs;
               rd_d      = rd;
               mode_d    = dec_mode;
               cmp_d     = dec_is_cmp;
               illegal_d = dec_illegal;
               if (dec_is_mov) begin
                  // Move-immediate skips the ALU: imm goes straight to write-back
                  result_d = imm;
                  state_d  = ST_WB;
               end else if (dec_is_alu) begin
                  state_d  = ST_READ;
               end else begin
                  state_d  = ST_DONE;
               end
            end
         end

         ST_READ: begin
            mem_enable      = 1'b1;
            read_write      = 1'b1;
            register_select = rs_q;
            mode            = mode_q;
            immediate_input = imm_q;
            cnt_d           = CNT_LOAD;
            state_d         = ST_ALU;
         end

         ST_ALU: begin
            alu_enable      = 1'b1;
            register_select = rs_q;
            mode            = mode_q;
            immediate_input = imm_q;
            if (cnt_q == '0) begin
               state_d = ST_CAP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_CAP: begin
            // Operands stay on the ALU inputs so the result is still valid here
            register_select = rs_q;
            mode            = mode_q;
            immediate_input = imm_q;
            result_d        = alu_result;
            zero_d          = alu_zero;
            carry_d         = alu_carry;
            state_d         = cmp_q ? ST_DONE : ST_WB;
         end

         ST_WB: begin
            mem_enable      = 1'b1;
            read_write      = 1'b0;
            register_select = rd_q;
            data_bus_in     = result_q;
            state_d         = ST_DONE;
         end

         ST_DONE: begin
            // start is deliberately not sampled here
            done    = 1'b1;
            illegal = illegal_q;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy       = (state_q != ST_IDLE);
   assign zero_flag  = zero_q;
   assign carry_flag = carry_q;

endmodule : alu_op_sequencer

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Self-checking bench for alu_op_sequencer. Surrounds the DUT with
//            a 4-entry register file and an 8-bit ALU, and predicts register
//            contents, flags, latency and bus activity per instruction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] opcode;
   logic [7:0] imm;
   logic [1:0] rs;
   logic [1:0] rd;
   logic [7:0] alu_result;
   logic       alu_zero;
   logic       alu_carry;
   logic [1:0] register_select;
   logic       mem_enable;
   logic       read_write;
   logic [7:0] data_bus_in;
   logic       alu_enable;
   logic [2:0] mode;
   logic [7:0] immediate_input;
   logic       busy;
   logic       done;
   logic       illegal;
   logic       zero_flag;
   logic       carry_flag;

   always #5 clk = ~clk;

   alu_op_sequencer #(
      .DATA_W   (8),
      .SEL_W    (2),
      .ALU_WAIT (1)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .opcode          (opcode),
      .imm             (imm),
      .rs              (rs),
      .rd              (rd),
      .alu_result      (alu_result),
      .alu_zero        (alu_zero),
      .alu_carry       (alu_carry),
      .register_select (register_select),
      .mem_enable      (mem_enable),
      .read_write      (read_write),
      .data_bus_in     (data_bus_in),
      .alu_enable      (alu_enable),
      .mode            (mode),
      .immediate_input (immediate_input),
      .busy            (busy),
      .done            (done),
      .illegal         (illegal),
      .zero_flag       (zero_flag),
      .carry_flag      (carry_flag)
   );

   // Register file: read data is registered, writes land on the clock edge
   logic [7:0] rf [4];
   logic [7:0] rd_data;
   int         wr_count = 0;

   always @(posedge clk) begin
      if (mem_enable && read_write) rd_data <= rf[register_select];
      if (mem_enable && !read_write) begin
         rf[register_select] <= data_bus_in;
         wr_count            <= wr_count + 1;
      end
   end

   // ALU: add, subtract (carry = borrow), logic ops, compare as subtract
   logic [8:0] alu_wide;
   always_comb begin
      case (mode)
         3'b000:         alu_wide = {1'b0, rd_data} + {1'b0, immediate_input};
         3'b001, 3'b111: alu_wide = {1'b0, rd_data} - {1'b0, immediate_input};
         3'b100:         alu_wide = {1'b0, rd_data & immediate_input};
         3'b101:         alu_wide = {1'b0, rd_data | immediate_input};
         3'b110:         alu_wide = {1'b0, rd_data ^ immediate_input};
         default:        alu_wide = '0;
      endcase
   end
   assign alu_result = alu_wide[7:0];
   assign alu_carry  = alu_wide[8];
   assign alu_zero   = (alu_wide[7:0] == 8'h00);

   // Reference model state
   logic [7:0] m_rf [4];
   logic       m_z = 1'b0;
   logic       m_c = 1'b0;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Instruction-level prediction: updates model registers/flags and
   // returns the expected latency, illegal bit, write count and ALU mode
   task automatic predict(input logic [3:0] op, input logic [7:0] b,
                          input logic [1:0] s, input logic [1:0] d,
                          output int lat, output logic ill, output int writes,
                          output logic [2:0] md, output logic uses_alu);
      logic [7:0] a;
      logic [8:0] w;
      int         kind;   // 0 ALU with write, 1 compare, 2 move, 3 illegal
      a    = m_rf[s];
      w    = '0;
      md   = 3'b000;
      kind = 0;
      case (op)
         4'b1100: begin w = {1'b0, a} + {1'b0, b}; md = 3'b000; end
         4'b1101: begin w = {1'b0, a} - {1'b0, b}; md = 3'b001; end
         4'b1110: begin w = {1'b0, a & b};         md = 3'b100; end
         4'b1001: begin w = {1'b0, a | b};         md = 3'b101; end
         4'b1011: begin w = {1'b0, a ^ b};         md = 3'b110; end
         4'b1111: begin w = {1'b0, a} - {1'b0, b}; md = 3'b111; kind = 1; end
         4'b0010: kind = 2;
         default: kind = 3;
      endcase
      ill      = (kind == 3);
      uses_alu = (kind < 2);
      writes   = (kind == 0 || kind == 2) ? 1 : 0;
      lat      = (kind == 0) ? 5 : (kind == 1) ? 4 : (kind == 2) ? 2 : 1;
      if (kind < 2) begin
         m_z = (w[7:0] == 8'h00);
         m_c = w[8];
      end
      if (kind == 0) m_rf[d] = w[7:0];
      if (kind == 2) m_rf[d] = b;
   endtask

   // Issue one instruction (entered in IDLE), scramble inputs while busy,
   // then check latency, illegal, flags, write count, ALU drive and registers
   task automatic run_op(input logic [3:0] op, input logic [7:0] b,
                         input logic [1:0] s, input logic [1:0] d);
      int         lat, writes, wr0, cyc;
      logic       ill, uses_alu, seen_alu, drive_ok, ill_seen;
      logic [2:0] md;
      predict(op, b, s, d, lat, ill, writes, md, uses_alu);
      wr0 = wr_count;
      @(negedge clk);
      opcode = op; imm = b; rs = s; rd = d; start = 1'b1;
      @(negedge clk);
      cyc      = 1;
      seen_alu = 1'b0;
      drive_ok = 1'b1;
      while (!done && cyc < 20) begin
         if (alu_enable) begin
            seen_alu = 1'b1;
            if (mode !== md || immediate_input !== b) drive_ok = 1'b0;
         end
         start  = 1'($urandom_range(0, 1));
         opcode = 4'($urandom);
         imm    = 8'($urandom);
         rs     = 2'($urandom);
         rd     = 2'($urandom);
         @(negedge clk);
         cyc++;
      end
      ill_seen = illegal;
      start    = 1'($urandom_range(0, 1));
      @(negedge clk);
      start = 1'b0;
      check("latency", 64'(cyc), 64'(lat));
      check("illegal", {63'd0, ill_seen}, {63'd0, ill});
      check("flags", {62'd0, zero_flag, carry_flag}, {62'd0, m_z, m_c});
      check("writes", 64'(wr_count - wr0), 64'(writes));
      check("alu_drive", {62'd0, seen_alu, drive_ok}, {62'd0, uses_alu, 1'b1});
      check("regs", {32'd0, rf[0], rf[1], rf[2], rf[3]},
                    {32'd0, m_rf[0], m_rf[1], m_rf[2], m_rf[3]});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         cyc, ndone, wr0, lat, writes, p0, p1, p2;
      logic       ill, uses_alu;
      logic [2:0] md;

      reset = 1'b1; start = 1'b0; opcode = '0; imm = '0; rs = '0; rd = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {36'd0, busy, done, illegal, mem_enable, read_write, alu_enable, mode,
             register_select, data_bus_in, immediate_input, zero_flag, carry_flag},
            {36'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000,
             2'b00, 8'h00, 8'h00, 1'b0, 1'b0});
      reset = 1'b0;

      // Preload register file through move-immediate
      run_op(4'b0010, 8'h29, 2'd0, 2'd0);
      run_op(4'b0010, 8'h00, 2'd0, 2'd1);
      run_op(4'b0010, 8'h5A, 2'd0, 2'd2);
      run_op(4'b0010, 8'h33, 2'd0, 2'd3);

      // Directed instructions
      run_op(4'b1110, 8'h07, 2'd0, 2'd1);   // ANI -> reg1 = 0x01
      run_op(4'b1100, 8'h07, 2'd0, 2'd1);   // SMI -> reg1 = 0x30
      run_op(4'b0010, 8'hFF, 2'd0, 2'd0);
      run_op(4'b1100, 8'h01, 2'd0, 2'd1);   // SMI wrap -> 0x00, zero, carry
      run_op(4'b0010, 8'h07, 2'd0, 2'd0);
      run_op(4'b1111, 8'h07, 2'd0, 2'd3);   // CMI equal -> zero, no write
      run_op(4'b0000, 8'h11, 2'd1, 2'd2);   // illegal
      run_op(4'b1101, 8'h08, 2'd0, 2'd2);   // SBI borrow

      // Reset while in the ALU state: leave flags set first
      run_op(4'b0010, 8'hFF, 2'd0, 2'd0);
      run_op(4'b1100, 8'h01, 2'd0, 2'd3);
      wr0 = wr_count;
      @(negedge clk);
      opcode = 4'b1110; imm = 8'h0F; rs = 2'd0; rd = 2'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      while (!alu_enable && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      check("reach_alu", {63'd0, alu_enable}, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_z   = 1'b0;
      m_c   = 1'b0;
      check("abort_state", {61'd0, busy, zero_flag, carry_flag}, 64'd0);
      ndone = 0;
      repeat (6) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("abort_no_done", 64'(ndone), 64'd0);
      check("abort_no_write", 64'(wr_count - wr0), 64'd0);
      check("abort_regs", {32'd0, rf[0], rf[1], rf[2], rf[3]},
                          {32'd0, m_rf[0], m_rf[1], m_rf[2], m_rf[3]});

      // Start held high for three back-to-back ANI instructions
      run_op(4'b0010, 8'hC6, 2'd0, 2'd3);
      lat = 0;
      repeat (3) predict(4'b1110, 8'h5F, 2'd3, 2'd1, lat, ill, writes, md, uses_alu);
      wr0 = wr_count;
      @(negedge clk);
      opcode = 4'b1110; imm = 8'h5F; rs = 2'd3; rd = 2'd1; start = 1'b1;
      cyc = 0; ndone = 0; p0 = 0; p1 = 0; p2 = 0;
      repeat (26) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            ndone++;
            if (ndone == 1) p0 = cyc;
            if (ndone == 2) p1 = cyc;
            if (ndone == 3) begin
               p2    = cyc;
               start = 1'b0;
            end
         end
      end
      check("b2b_done_count", 64'(ndone), 64'd3);
      check("b2b_done_cycles", {16'd0, 16'(p0), 16'(p1), 16'(p2)},
            {16'd0, 16'(lat), 16'(2 * lat + 1), 16'(3 * lat + 2)});
      check("b2b_writes", 64'(wr_count - wr0), 64'd3);
      check("b2b_regs", {30'd0, zero_flag, carry_flag, rf[0], rf[1], rf[2], rf[3]},
            {30'd0, m_z, m_c, m_rf[0], m_rf[1], m_rf[2], m_rf[3]});

      // Randomized instruction stream
      for (int i = 0; i < 60; i++) begin
         run_op(4'($urandom), 8'($urandom), 2'($urandom), 2'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_alu_op_sequencer

`default_nettype wire
